core_control_ldst_pop: RTL

CORE_CONTROL_LDST_POP -- requirements
Module: core_control_ldst_pop

---
 rtl/core_control_ldst_pop_pkg.sv | 10 +
 rtl/core_control_ldst_pop_prio.sv | 15 +
 rtl/core_control_ldst_pop.sv | 82 ++++++++
 3 files changed

// File: rtl/core_control_ldst_pop_pkg.sv
// core_control_ldst_pop_pkg: shared types and helpers for the LDM/STM register-list sequencer
package core_control_ldst_pop_pkg;
   typedef logic [3:0]  reg_num;
   typedef logic [29:0] ptr;
   typedef enum logic [1:0] {IDLE, RUN, DONE} ldst_state_e;
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      popcount16 = '0;
      for (int i = 0; i < 16; i++) popcount16 += 5'(v[i]);
   endfunction
endpackage

// File: rtl/core_control_ldst_pop_prio.sv
// core_control_ldst_pop_prio: lowest-set-bit priority encoder, 16 to 4 plus valid
module core_control_ldst_pop_prio
   import core_control_ldst_pop_pkg::*;
(
   input  logic [15:0] bits_i,
   output reg_num      idx_o,
   output logic        valid_o
);
   assign valid_o = |bits_i;
   // scan from the top so the lowest set bit is written last and wins
   always_comb begin
      idx_o = '0;
      for (int i = 15; i >= 0; i--) if (bits_i[i]) idx_o = reg_num'(i);
   end
endmodule

// File: rtl/core_control_ldst_pop.sv
// core_control_ldst_pop: LDM/STM register-list sequencer; CORE_LDST_PC_FLAG_EN adds pc_in_list output
module core_control_ldst_pop
   import core_control_ldst_pop_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] reg_list,
   input  ptr          base,
   input  logic        increment,
   input  logic        pre_index,
   input  logic        pop,
   output logic        pop_valid,
   output reg_num      popped,
   output ptr          addr,
   output logic        last,
   output ptr          writeback,
   output logic        done
`ifdef CORE_LDST_PC_FLAG_EN
   ,
   output logic        pc_in_list
`endif
);
   ldst_state_e state_q, state_d;
   logic [15:0] list_q, list_d;
   ptr          addr_q, addr_d, wb_q, wb_d, first;
   logic [4:0]  n;
   logic        any, take;
   core_control_ldst_pop_prio u_prio (.bits_i(list_q), .idx_o(popped), .valid_o(any));
   // registers always go out lowest first at ascending addresses, so descending
   // modes just start n words below base
   assign n         = popcount16(reg_list);
   assign first     = (increment ? base : base - ptr'(n)) + ptr'(increment == pre_index);
   assign pop_valid = (state_q == RUN) && any;
   assign last      = pop_valid && ((list_q & (list_q - 16'd1)) == 16'd0);
   assign take      = pop_valid && pop;
   assign done      = state_q == DONE;
   assign addr      = addr_q;
   assign writeback = wb_q;
   // next state: start beats pop, pop retires the lowest bit, DONE lasts one cycle
   always_comb begin
      state_d = state_q;
      list_d  = list_q;
      addr_d  = addr_q;
      wb_d    = wb_q;
      if (start) begin
         state_d = (n != 5'd0) ? RUN : DONE;
         list_d  = reg_list;
         addr_d  = first;
         wb_d    = increment ? base + ptr'(n) : base - ptr'(n);
      end else if (take) begin
         state_d = last ? DONE : RUN;
         list_d  = list_q & (list_q - 16'd1);
         addr_d  = addr_q + ptr'(1);
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         list_q  <= '0;
         addr_q  <= '0;
         wb_q    <= '0;
      end else begin
         state_q <= state_d;
         list_q  <= list_d;
         addr_q  <= addr_d;
         wb_q    <= wb_d;
      end
   end
`ifdef CORE_LDST_PC_FLAG_EN
   logic pc_q;
   assign pc_in_list = pc_q;
   // pc flag: captured at start, dropped once r15 leaves or the list completes
   always_ff @(posedge clk) begin
      if (rst) pc_q <= 1'b0;
      else pc_q <= start ? reg_list[15] : ((take && popped == 4'd15) || state_d == DONE) ? 1'b0 : pc_q;
   end
`endif
endmodule
